lr_car_sensor: RTL
==================

// Module: lr_car_sensor
// PURPOSE
// - Upstream stage of the traffic light controller. Conditions the raw local-road loop-detector input.
// - Counts cars queued on the local road and drives lr_has_car into the controller.
// - Watches the controller's lr_light output to retire queued cars while the local road is green.
// PARAMETERS
// - DEB_CYC     16    consecutive synced-sample cycles required to accept a sensor level change (>=2)
// - DEPART_CYC  50    green cycles per departing car (>=2)
// - MAX_CARS    15    saturation value of car_count
// - COUNT_W     4     width of car_count; must satisfy 2**COUNT_W > MAX_CARS
// - STUCK_CYC   1000  cycles of continuous debounced presence that flag a stuck sensor (macro only)
// PORTS
// - clk           in   1        system clock, rising edge
// - rst_n         in   1        reset; asynchronous, active-low
// - sensor_raw    in   1        loop detector, asynchronous to clk, 1 = metal over loop
// - lr_light      in   3        controller local-road light, one-hot: Red=001, Yellow=010, Green=100
// - lr_has_car    out  1        registered; 1 when car_count != 0 (or when the stuck-sensor fault is set)
// - car_count     out  COUNT_W  registered count of queued cars
// - arrive_pulse  out  1        one-cycle pulse per accepted car arrival
// BEHAVIOUR
// - Reset (async, rst_n=0): sync flops 0, FSM OFF, deb_cnt 0, dep_tmr 0, car_count 0, lr_has_car 0, arrive_pulse 0.
// - Synchronizer: sensor_raw passes through 2 flops to produce s_sync. It adds 2 cycles of latency.
// - Debounce FSM, four states:
//   - OFF: if s_sync=1, go to ON_PEND with deb_cnt=1.
//   - ON_PEND: if s_sync=0, go to OFF and clear deb_cnt.
//     Else if deb_cnt==DEB_CYC-1, go to ON and clear deb_cnt. Else increment deb_cnt.
//   - ON: if s_sync=0, go to OFF_PEND with deb_cnt=1.
//   - OFF_PEND: mirror of ON_PEND, returning to OFF on the count and to ON if s_sync=1.
// - Arrival: the edge that enters ON sets arrive_pulse=1 for exactly one cycle.
//   - The same edge increments car_count, saturating at MAX_CARS (no wrap).
//   - A car must leave the loop (reach OFF) before another arrival is possible.
// - Departure timer dep_tmr:
//   - Runs only while lr_light==3'b100 and car_count!=0.
//   - At dep_tmr==DEPART_CYC-1: dep_tmr goes to 0 and car_count decrements.
//   - Cleared to 0 whenever lr_light!=Green or car_count==0; partial progress is discarded.
//   - Yellow, red and illegal codes all count as not-green.
// - Simultaneous arrival and departure on the same edge: car_count unchanged, arrive_pulse still 1.
// - Arrival at MAX_CARS: count stays at MAX_CARS, pulse still issued.
// - Decrement never occurs when car_count==0.
// - lr_has_car is registered from the next value of car_count, so it changes on the same edge as car_count.
// - Latency, raw rise to car_count increment: 2 + DEB_CYC edges once sensor_raw is stable high.
// - Reset mid-operation: every register returns to its reset value immediately; queued cars are lost.
// CONFIGURATION
// - Macro LR_STUCK_SENSOR_EN.
// - Defined:
//   - Counter stk_cnt increments every cycle the FSM is in ON or OFF_PEND and clears in OFF or ON_PEND.
//   - At stk_cnt==STUCK_CYC-1, the sticky register sensor_fault is set. It clears only on reset.
//   - Added output port: sensor_fault  out  1.
//   - While sensor_fault=1, lr_has_car is forced to 1; car_count and departures behave as normal.
// - Undefined: no stk_cnt, no sensor_fault port; lr_has_car = (car_count != 0) only.
// TESTING
// Bench parameters: DEB_CYC=4, DEPART_CYC=10, MAX_CARS=7, COUNT_W=3, STUCK_CYC=20.
// - Glitch rejection: sensor_raw high for 3 cycles, then low for 10 -> arrive_pulse never 1, car_count 0.
// - Single car: sensor_raw high for 8 cycles, lr_light Red -> one arrive_pulse exactly 6 edges after the rise.
//   car_count 0->1 and lr_has_car 0->1 on that same edge.
// - Departure: car_count=3, lr_light Green -> decrements every 10 cycles to 0, then lr_has_car 0.
//   Switching to Yellow at 5 cycles into a departure -> no decrement; timer restarts at 0 on the next Green.
// - Saturation and simultaneous events:
//   - 9 debounced arrivals under Red -> car_count 7, 9 pulses.
//   - An arrival on the same edge as a departure under Green -> count unchanged.
// - Async reset: assert rst_n=0 mid-ON_PEND with car_count=2 -> all outputs 0 without a clock edge.
//   After release, sensor_raw must be stable 4 synced cycles again before a new arrival.
// - LR_STUCK_SENSOR_EN: sensor held high 30 cycles -> sensor_fault=1 and lr_has_car=1 even with car_count at 0 under Green.
//   The fault persists after the sensor drops and clears only on reset.

Source files
------------

// File: rtl/lr_car_sensor_if.sv
// Local-road sensor bundle: raw loop input and light in, queue status out.
// sensor_fault exists only when LR_STUCK_SENSOR_EN is defined.
interface lr_car_sensor_if #(
   parameter int unsigned COUNT_W = 4
);
   logic               sensor_raw;
   logic [2:0]         lr_light;
   logic               lr_has_car;
   logic [COUNT_W-1:0] car_count;
   logic               arrive_pulse;
`ifdef LR_STUCK_SENSOR_EN
   logic               sensor_fault;

   modport master (
      output sensor_raw, lr_light,
      input  lr_has_car, car_count, arrive_pulse, sensor_fault
   );
   modport slave (
      input  sensor_raw, lr_light,
      output lr_has_car, car_count, arrive_pulse, sensor_fault
   );
`else
   modport master (
      output sensor_raw, lr_light,
      input  lr_has_car, car_count, arrive_pulse
   );
   modport slave (
      input  sensor_raw, lr_light,
      output lr_has_car, car_count, arrive_pulse
   );
`endif
endinterface

// File: rtl/lr_car_sensor.sv
// Local-road loop detector conditioning: sync, debounce, car queue count, departures.
// Optional stuck-sensor detection is enabled by defining LR_STUCK_SENSOR_EN.
module lr_car_sensor #(
   parameter int unsigned DEB_CYC    = 16,
   parameter int unsigned DEPART_CYC = 50,
   parameter int unsigned MAX_CARS   = 15,
   parameter int unsigned COUNT_W    = 4
`ifdef LR_STUCK_SENSOR_EN
   ,
   parameter int unsigned STUCK_CYC  = 1000
`endif
) (
   input logic             clk,
   input logic             rst_n,
   lr_car_sensor_if.slave  sns
);

   localparam int unsigned DW = $clog2(DEB_CYC);
   localparam int unsigned TW = $clog2(DEPART_CYC);
   localparam logic [DW-1:0]      DEB_LAST = DW'(DEB_CYC - 1);
   localparam logic [TW-1:0]      DEP_LAST = TW'(DEPART_CYC - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_CARS);

   typedef enum logic [1:0] {
      S_OFF,
      S_ON_PEND,
      S_ON,
      S_OFF_PEND
   } deb_state_e;

   logic               s_meta_q, s_sync_q;
   deb_state_e         state_q, state_d;
   logic [DW-1:0]      deb_cnt_q, deb_cnt_d;
   logic [TW-1:0]      dep_tmr_q, dep_tmr_d;
   logic [COUNT_W-1:0] car_count_q, car_count_d;
   logic               has_car_q, has_car_d;
   logic               arrive_q;
   logic               arrive;
   logic               dep_run, dep_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_meta_q <= 1'b0;
         s_sync_q <= 1'b0;
      end else begin
         s_meta_q <= sns.sensor_raw;
         s_sync_q <= s_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_OFF;
         deb_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Entering ON is the only arrival event; a car must reach OFF before the next one.
   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      arrive    = 1'b0;
      case (state_q)
         S_OFF: begin
            if (s_sync_q) begin
               state_d   = S_ON_PEND;
               deb_cnt_d = DW'(1);
            end
         end
         S_ON_PEND: begin
            if (!s_sync_q) begin
               state_d   = S_OFF;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = S_ON;
               deb_cnt_d = '0;
               arrive    = 1'b1;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         S_ON: begin
            if (!s_sync_q) begin
               state_d   = S_OFF_PEND;
               deb_cnt_d = DW'(1);
            end
         end
         S_OFF_PEND: begin
            if (s_sync_q) begin
               state_d   = S_ON;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = S_OFF;
               deb_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = S_OFF;
            deb_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      dep_run   = (sns.lr_light == 3'b100) && (car_count_q != '0);
      dep_done  = dep_run && (dep_tmr_q == DEP_LAST);
      dep_tmr_d = (!dep_run || dep_done) ? '0 : dep_tmr_q + 1'b1;

      car_count_d = car_count_q;
      case ({arrive, dep_done})
         2'b10:   car_count_d = (car_count_q == CNT_MAX) ? car_count_q : car_count_q + 1'b1;
         2'b01:   car_count_d = car_count_q - 1'b1;
         default: car_count_d = car_count_q;
      endcase
   end

`ifdef LR_STUCK_SENSOR_EN
   localparam int unsigned SW = $clog2(STUCK_CYC);
   localparam logic [SW-1:0] STK_LAST = SW'(STUCK_CYC - 1);

   logic [SW-1:0] stk_cnt_q, stk_cnt_d;
   logic          fault_q, fault_d;

   // Counter parks at its last value once the sticky fault is raised.
   always_comb begin
      stk_cnt_d = '0;
      fault_d   = fault_q;
      if (state_q == S_ON || state_q == S_OFF_PEND) begin
         if (stk_cnt_q == STK_LAST) begin
            fault_d   = 1'b1;
            stk_cnt_d = stk_cnt_q;
         end else begin
            stk_cnt_d = stk_cnt_q + 1'b1;
         end
      end
      has_car_d = (car_count_d != '0) || fault_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stk_cnt_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         stk_cnt_q <= stk_cnt_d;
         fault_q   <= fault_d;
      end
   end

   assign sns.sensor_fault = fault_q;
`else
   always_comb begin
      has_car_d = (car_count_d != '0);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dep_tmr_q   <= '0;
         car_count_q <= '0;
         has_car_q   <= 1'b0;
         arrive_q    <= 1'b0;
      end else begin
         dep_tmr_q   <= dep_tmr_d;
         car_count_q <= car_count_d;
         has_car_q   <= has_car_d;
         arrive_q    <= arrive;
      end
   end

   assign sns.car_count    = car_count_q;
   assign sns.lr_has_car   = has_car_q;
   assign sns.arrive_pulse = arrive_q;

endmodule
